// File: rtl/oledrgb_pkg.sv
// Shared types and helpers for the OLEDrgb SPI transmit path.
// Byte bundle, FSM states and bit-order helpers.
package oledrgb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD
    } spi_state_e;

    typedef struct packed {
        logic       dc;
        logic [7:0] data;
    } oled_byte_t;

    localparam bit SPI_MSB_FIRST = 1'b1;
    localparam bit SCLK_IDLE     = 1'b1;

    function automatic logic lead_bit(input logic [7:0] d);
        return SPI_MSB_FIRST ? d[7] : d[0];
    endfunction

    function automatic logic [7:0] advance(input logic [7:0] d);
        return SPI_MSB_FIRST ? {d[6:0], 1'b0} : {1'b0, d[7:1]};
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/oledrgb_byte_fifo.sv
// Small synchronous queue of command/data bytes.
// Level is registered so ready never depends on valid.
module oledrgb_byte_fifo
    import oledrgb_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  oled_byte_t    wr_data,
    input  logic          pop,
    output oled_byte_t    rd_data,
    output logic          full,
    output logic          empty,
    output logic [LW-1:0] level
);

    oled_byte_t    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    // Storage array, no reset needed on payload.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally; level tracks occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push_ok, pop_ok})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/oledrgb_spi_tx.sv
// Byte queue plus SPI mode-3 shifter for the PmodOLEDrgb.
// MSB first, D/C follows each byte, CS_n guarded both ends.
module oledrgb_spi_tx
    import oledrgb_pkg::*;
#(
    parameter  int CLK_DIV    = 5,
    parameter  int FIFO_DEPTH = 4,
    parameter  int CS_GUARD   = 5,
    localparam int LW         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic          ACLK,
    input  logic          ARESETN,
    input  logic [7:0]    s_data,
    input  logic          s_dc,
    input  logic          s_valid,
    output logic          s_ready,
    output logic          busy,
    output logic [LW-1:0] fifo_level,
    output logic          oled_cs_n,
    output logic          oled_sclk,
    output logic          oled_sdin,
    output logic          oled_dc
);

    localparam int HW = $clog2(CLK_DIV);
    localparam int GW = $clog2(max_int(CS_GUARD, CLK_DIV) + 1);

    localparam logic [HW-1:0] H_LAST = HW'(CLK_DIV - 1);
    localparam logic [GW-1:0] G_LAST = GW'(CS_GUARD - 1);
    localparam logic [GW-1:0] G_HI   = GW'(CLK_DIV);

    spi_state_e    state;
    logic [HW-1:0] hcnt;
    logic [2:0]    bcnt;
    logic [GW-1:0] gcnt;
    logic [7:0]    shreg;

    oled_byte_t    head;
    oled_byte_t    wr_byte;
    logic          empty;
    logic          full;
    logic          pop;
    logic          end_hi;
    logic          last_bit;

    assign wr_byte  = '{dc: s_dc, data: s_data};
    assign s_ready  = !full;
    assign busy     = (state != IDLE) || !empty;
    assign end_hi   = (hcnt == H_LAST) && oled_sclk;
    assign last_bit = (bcnt == 3'd7);

    assign pop = !empty && (
        (state == IDLE) ||
        (state == SHIFT && end_hi && last_bit));

    oledrgb_byte_fifo #(
        .DEPTH   (FIFO_DEPTH)
    ) u_fifo (
        .clk     (ACLK),
        .rst_n   (ARESETN),
        .push    (s_valid && s_ready),
        .wr_data (wr_byte),
        .pop     (pop),
        .rd_data (head),
        .full    (full),
        .empty   (empty),
        .level   (fifo_level)
    );

    // Transfer FSM driving all pins from registers.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state     <= IDLE;
            hcnt      <= '0;
            bcnt      <= '0;
            gcnt      <= '0;
            shreg     <= '0;
            oled_cs_n <= 1'b1;
            oled_sclk <= SCLK_IDLE;
            oled_sdin <= 1'b0;
            oled_dc   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (!empty) begin
                        shreg     <= head.data;
                        oled_dc   <= head.dc;
                        oled_cs_n <= 1'b0;
                        gcnt      <= '0;
                        state     <= SETUP;
                    end
                end
                SETUP: begin
                    if (gcnt == G_LAST) begin
                        oled_sclk <= 1'b0;
                        oled_sdin <= lead_bit(shreg);
                        shreg     <= advance(shreg);
                        hcnt      <= '0;
                        bcnt      <= '0;
                        state     <= SHIFT;
                    end else begin
                        gcnt <= gcnt + 1'b1;
                    end
                end
                SHIFT: begin
                    if (hcnt != H_LAST) begin
                        hcnt <= hcnt + 1'b1;
                    end else begin
                        hcnt <= '0;
                        if (!oled_sclk) begin
                            oled_sclk <= 1'b1;
                        end else if (!last_bit) begin
                            oled_sclk <= 1'b0;
                            oled_sdin <= lead_bit(shreg);
                            shreg     <= advance(shreg);
                            bcnt      <= bcnt + 3'd1;
                        end else if (!empty) begin
                            oled_sclk <= 1'b0;
                            oled_dc   <= head.dc;
                            oled_sdin <= lead_bit(head.data);
                            shreg     <= advance(head.data);
                            bcnt      <= '0;
                        end else if (CLK_DIV >= CS_GUARD) begin
                            oled_cs_n <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            // Hold time runs from the last
                            // rising edge; the final high
                            // phase already used CLK_DIV.
                            gcnt  <= G_HI;
                            state <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (gcnt == G_LAST) begin
                        oled_cs_n <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        gcnt <= gcnt + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_oledrgb_spi_tx.sv
// Self-checking bench for oledrgb_spi_tx.
// Pin monitor decodes SPI bytes against a scoreboard queue.
module tb_oledrgb_spi_tx;

    logic       ACLK = 1'b0;
    logic       ARESETN = 1'b0;

    logic [7:0] s_data = '0;
    logic       s_dc = 1'b0;
    logic       s_valid = 1'b0;
    logic       s_ready, busy;
    logic [2:0] fifo_level;
    logic       oled_cs_n, oled_sclk, oled_sdin, oled_dc;

    logic [7:0] s_data2 = '0;
    logic       s_dc2 = 1'b0;
    logic       s_valid2 = 1'b0;
    logic       s_ready2, busy2;
    logic [2:0] level2;
    logic       cs2, sclk2, sdin2, dc2;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic [8:0] sb0 [$];
    logic [8:0] sb1 [$];

    always #5 ACLK = ~ACLK;

    always @(posedge ACLK) cyc <= cyc + 1;

    oledrgb_spi_tx dut (
        .ACLK       (ACLK),
        .ARESETN    (ARESETN),
        .s_data     (s_data),
        .s_dc       (s_dc),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .busy       (busy),
        .fifo_level (fifo_level),
        .oled_cs_n  (oled_cs_n),
        .oled_sclk  (oled_sclk),
        .oled_sdin  (oled_sdin),
        .oled_dc    (oled_dc)
    );

    oledrgb_spi_tx #(.CLK_DIV(2)) dut2 (
        .ACLK       (ACLK),
        .ARESETN    (ARESETN),
        .s_data     (s_data2),
        .s_dc       (s_dc2),
        .s_valid    (s_valid2),
        .s_ready    (s_ready2),
        .busy       (busy2),
        .fifo_level (level2),
        .oled_cs_n  (cs2),
        .oled_sclk  (sclk2),
        .oled_sdin  (sdin2),
        .oled_dc    (dc2)
    );

    logic       p_c [2] = '{1'b1, 1'b1};
    logic       p_s [2] = '{1'b1, 1'b1};
    logic       p_d [2] = '{1'b0, 1'b0};
    int         cs_fall [2], last_rise [2];
    int         pmin [2], pmax [2];
    int         setup [2], hold [2];
    int         rises [2], wins [2], bits [2];
    int         nfall [2], nbytes [2];
    logic       have_rise [2] = '{1'b0, 1'b0};
    logic       busy_rise [2] = '{1'b1, 1'b1};
    logic       dcv [2] = '{1'b0, 1'b0};
    logic       dcbad [2] = '{1'b0, 1'b0};
    logic [7:0] sh [2];

    // Pin monitor: decode bytes, timing, scoreboard compare.
    always @(negedge ACLK) begin
        logic       c [2];
        logic       s [2];
        logic       d [2];
        logic       x [2];
        logic       b [2];
        logic [8:0] exp_b;
        logic       have;
        c[0] = oled_cs_n; s[0] = oled_sclk;
        d[0] = oled_sdin; x[0] = oled_dc; b[0] = busy;
        c[1] = cs2; s[1] = sclk2;
        d[1] = sdin2; x[1] = dc2; b[1] = busy2;
        for (int k = 0; k < 2; k++) begin
            if (!ARESETN) begin
                bits[k] = 0;
                dcbad[k] = 1'b0;
                if (k == 0) sb0.delete();
                else sb1.delete();
            end else begin
                if (s[k] != p_s[k]) begin
                    checks++;
                    if (p_c[k] && c[k]) begin
                        errors++;
                        $display("FAIL sclk_idle dut%0d: sclk=%0b moved, required no edge with cs_n=1",
                                 k, s[k]);
                    end
                end
                if (!c[k] && p_c[k]) begin
                    cs_fall[k] = cyc;
                    nfall[k] = 0;
                    pmin[k] = 1000000;
                    pmax[k] = 0;
                    have_rise[k] = 1'b0;
                    wins[k]++;
                end
                if (!c[k] && p_s[k] && !s[k]) begin
                    if (nfall[k] == 0) setup[k] = cyc - cs_fall[k];
                    nfall[k]++;
                end
                if (!c[k] && !p_s[k] && s[k]) begin
                    if (have_rise[k]) begin
                        if (cyc - last_rise[k] < pmin[k])
                            pmin[k] = cyc - last_rise[k];
                        if (cyc - last_rise[k] > pmax[k])
                            pmax[k] = cyc - last_rise[k];
                    end
                    have_rise[k] = 1'b1;
                    last_rise[k] = cyc;
                    rises[k]++;
                    checks++;
                    if (d[k] !== p_d[k]) begin
                        errors++;
                        $display("FAIL sdin_stable dut%0d: sdin=%0b at rise, required %0b",
                                 k, d[k], p_d[k]);
                    end
                    sh[k] = {sh[k][6:0], d[k]};
                    if (bits[k] == 0) dcv[k] = x[k];
                    else if (x[k] !== dcv[k]) dcbad[k] = 1'b1;
                    bits[k]++;
                    if (bits[k] == 8) begin
                        checks++;
                        have = (k == 0) ? (sb0.size() != 0)
                                        : (sb1.size() != 0);
                        if (!have) begin
                            errors++;
                            $display("FAIL sb_extra dut%0d: got %h, required no byte",
                                     k, {dcv[k], sh[k]});
                        end else begin
                            exp_b = (k == 0) ? sb0.pop_front()
                                             : sb1.pop_front();
                            if ({dcv[k], sh[k]} !== exp_b || dcbad[k]) begin
                                errors++;
                                $display("FAIL sb_byte dut%0d: got dc/data %h (dc_glitch=%0b), required %h",
                                         k, {dcv[k], sh[k]}, dcbad[k], exp_b);
                            end
                        end
                        nbytes[k]++;
                        bits[k] = 0;
                        dcbad[k] = 1'b0;
                    end
                end
                if (c[k] && !p_c[k]) begin
                    hold[k] = cyc - last_rise[k];
                    busy_rise[k] = b[k];
                end
            end
            p_c[k] = c[k];
            p_s[k] = s[k];
            p_d[k] = d[k];
        end
    end

    task automatic push(input int k, input logic dc,
                        input logic [7:0] d, output int stall);
        logic ok;
        logic rdy;
        ok = 1'b0;
        stall = 0;
        if (k == 0) begin
            s_valid = 1'b1; s_dc = dc; s_data = d;
        end else begin
            s_valid2 = 1'b1; s_dc2 = dc; s_data2 = d;
        end
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(negedge ACLK);
            rdy = (k == 0) ? s_ready : s_ready2;
            if (rdy) begin
                ok = 1'b1;
                if (k == 0) sb0.push_back({dc, d});
                else sb1.push_back({dc, d});
            end else begin
                stall++;
            end
            @(posedge ACLK);
            #1;
        end
        if (k == 0) s_valid = 1'b0;
        else s_valid2 = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL push_timeout dut%0d: byte %h not accepted, required accept",
                     k, d);
        end
    endtask

    task automatic wait_idle(input int k);
        logic done;
        done = 1'b0;
        for (int i = 0; i < 5000 && !done; i++) begin
            @(negedge ACLK);
            if (k == 0) done = !busy && oled_cs_n;
            else done = !busy2 && cs2;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout dut%0d: busy still 1, required 0", k);
        end
        @(posedge ACLK);
        #1;
    endtask

    task automatic test_reset();
        ARESETN = 1'b0;
        #200;
        ARESETN = 1'b1;
        repeat (100) @(posedge ACLK);
        @(negedge ACLK);
        checks += 7;
        if (oled_cs_n !== 1'b1) begin errors++;
            $display("FAIL rst_cs_n: got %b, required 1", oled_cs_n); end
        if (oled_sclk !== 1'b1) begin errors++;
            $display("FAIL rst_sclk: got %b, required 1", oled_sclk); end
        if (oled_sdin !== 1'b0) begin errors++;
            $display("FAIL rst_sdin: got %b, required 0", oled_sdin); end
        if (busy !== 1'b0) begin errors++;
            $display("FAIL rst_busy: got %b, required 0", busy); end
        if (s_ready !== 1'b1) begin errors++;
            $display("FAIL rst_ready: got %b, required 1", s_ready); end
        if (fifo_level !== 3'd0) begin errors++;
            $display("FAIL rst_level: got %0d, required 0", fifo_level); end
        if (rises[0] != 0) begin errors++;
            $display("FAIL rst_edges: got %0d, required 0", rises[0]); end
        @(posedge ACLK);
        #1;
    endtask

    task automatic test_single();
        int w0, r0, st;
        w0 = wins[0];
        r0 = rises[0];
        push(0, 1'b0, 8'hAE, st);
        wait_idle(0);
        checks += 7;
        if (wins[0] - w0 != 1) begin errors++;
            $display("FAIL single_windows: got %0d, required 1", wins[0] - w0); end
        if (rises[0] - r0 != 8) begin errors++;
            $display("FAIL single_rises: got %0d, required 8", rises[0] - r0); end
        if (setup[0] != 5) begin errors++;
            $display("FAIL single_setup: got %0d, required 5", setup[0]); end
        if (hold[0] != 5) begin errors++;
            $display("FAIL single_hold: got %0d, required 5", hold[0]); end
        if (pmin[0] != 10 || pmax[0] != 10) begin errors++;
            $display("FAIL single_period: got %0d..%0d, required 10",
                     pmin[0], pmax[0]); end
        if (busy_rise[0] !== 1'b0) begin errors++;
            $display("FAIL single_busy: got %b at cs_n rise, required 0",
                     busy_rise[0]); end
        if (sb0.size() != 0) begin errors++;
            $display("FAIL single_sb: got %0d left, required 0", sb0.size()); end
    endtask

    task automatic test_back_to_back();
        int w0, r0, st;
        w0 = wins[0];
        r0 = rises[0];
        push(0, 1'b0, 8'h15, st);
        push(0, 1'b1, 8'h00, st);
        push(0, 1'b1, 8'h5F, st);
        wait_idle(0);
        checks += 4;
        if (wins[0] - w0 != 1) begin errors++;
            $display("FAIL b2b_windows: got %0d, required 1", wins[0] - w0); end
        if (rises[0] - r0 != 24) begin errors++;
            $display("FAIL b2b_rises: got %0d, required 24", rises[0] - r0); end
        if (pmin[0] != 10 || pmax[0] != 10) begin errors++;
            $display("FAIL b2b_period: got %0d..%0d, required 10",
                     pmin[0], pmax[0]); end
        if (sb0.size() != 0) begin errors++;
            $display("FAIL b2b_sb: got %0d left, required 0", sb0.size()); end
    endtask

    task automatic test_burst();
        int st, st_sum, r0, n0;
        logic [7:0] d;
        r0 = rises[0];
        n0 = nbytes[0];
        st_sum = 0;
        for (int i = 0; i < 5; i++) begin
            d = 8'($urandom);
            push(0, 1'($urandom), d, st);
            st_sum += st;
        end
        @(negedge ACLK);
        checks += 4;
        if (st_sum != 0) begin errors++;
            $display("FAIL burst_stall: got %0d stalls, required 0", st_sum); end
        if (fifo_level !== 3'd4) begin errors++;
            $display("FAIL burst_level: got %0d, required 4", fifo_level); end
        if (s_ready !== 1'b0) begin errors++;
            $display("FAIL burst_ready: got %b, required 0", s_ready); end
        if (oled_cs_n !== 1'b0) begin errors++;
            $display("FAIL burst_started: cs_n=%b, required 0", oled_cs_n); end
        @(posedge ACLK);
        #1;
        st_sum = 0;
        for (int i = 0; i < 4; i++) begin
            d = 8'($urandom);
            push(0, 1'($urandom), d, st);
            st_sum += st;
        end
        wait_idle(0);
        checks += 4;
        if (st_sum == 0) begin errors++;
            $display("FAIL full_stall: got 0 stalls, required >0"); end
        if (nbytes[0] - n0 != 9) begin errors++;
            $display("FAIL full_count: got %0d bytes, required 9",
                     nbytes[0] - n0); end
        if (rises[0] - r0 != 72) begin errors++;
            $display("FAIL full_rises: got %0d, required 72", rises[0] - r0); end
        if (sb0.size() != 0) begin errors++;
            $display("FAIL full_sb: got %0d left, required 0", sb0.size()); end
    endtask

    task automatic test_reset_mid();
        int r0, st;
        r0 = rises[0];
        push(0, 1'b1, 8'hC3, st);
        push(0, 1'b1, 8'h3C, st);
        push(0, 1'b0, 8'h81, st);
        for (int i = 0; i < 100 && (cyc - cs_fall[0]) < 37; i++) begin
            @(posedge ACLK);
            #1;
        end
        checks++;
        if (rises[0] - r0 != 3) begin errors++;
            $display("FAIL mid_position: got %0d rises, required 3",
                     rises[0] - r0); end
        ARESETN = 1'b0;
        #1;
        checks += 2;
        if (oled_cs_n !== 1'b1) begin errors++;
            $display("FAIL mid_cs_n: got %b, required 1", oled_cs_n); end
        if (oled_sclk !== 1'b1) begin errors++;
            $display("FAIL mid_sclk: got %b, required 1", oled_sclk); end
        repeat (3) @(posedge ACLK);
        #1;
        ARESETN = 1'b1;
        @(negedge ACLK);
        r0 = rises[0];
        checks += 2;
        if (fifo_level !== 3'd0) begin errors++;
            $display("FAIL mid_level: got %0d, required 0", fifo_level); end
        if (busy !== 1'b0) begin errors++;
            $display("FAIL mid_busy: got %b, required 0", busy); end
        repeat (50) @(negedge ACLK);
        checks += 2;
        if (rises[0] != r0) begin errors++;
            $display("FAIL mid_edges: got %0d, required 0", rises[0] - r0); end
        if (oled_cs_n !== 1'b1) begin errors++;
            $display("FAIL mid_cs_after: got %b, required 1", oled_cs_n); end
        @(posedge ACLK);
        #1;
    endtask

    task automatic test_clkdiv2();
        int w1, r1, st;
        w1 = wins[1];
        r1 = rises[1];
        push(1, 1'b1, 8'hFF, st);
        push(1, 1'b1, 8'h00, st);
        wait_idle(1);
        checks += 6;
        if (wins[1] - w1 != 1) begin errors++;
            $display("FAIL div2_windows: got %0d, required 1", wins[1] - w1); end
        if (rises[1] - r1 != 16) begin errors++;
            $display("FAIL div2_rises: got %0d, required 16", rises[1] - r1); end
        if (pmin[1] != 4 || pmax[1] != 4) begin errors++;
            $display("FAIL div2_period: got %0d..%0d, required 4",
                     pmin[1], pmax[1]); end
        if (setup[1] != 5) begin errors++;
            $display("FAIL div2_setup: got %0d, required 5", setup[1]); end
        if (hold[1] != 5) begin errors++;
            $display("FAIL div2_hold: got %0d, required 5", hold[1]); end
        if (sb1.size() != 0) begin errors++;
            $display("FAIL div2_sb: got %0d left, required 0", sb1.size()); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_burst();
        test_reset_mid();
        test_clkdiv2();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: sim time limit reached, required finish");
        $fatal(1, "watchdog");
    end

endmodule
